// File: rtl/sbox_loader_pkg.sv
// Shared types and helpers for the S-box loader slice.
// The read-back verify path is enabled by defining SBOX_LOADER_VERIFY_EN.
package sbox_loader_pkg;

    localparam int unsigned SBOX_WORDS = 16;
    localparam int unsigned SBOX_AW    = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        DONE
    } state_t;

    // Rotate-left-by-one then XOR: one step of the load signature.
    function automatic logic [31:0] sig_step(input logic [31:0] sig, input logic [31:0] word);
        return {sig[30:0], sig[31]} ^ word;
    endfunction

endpackage

// File: rtl/sbox_loader_sig.sv
// Rotate-XOR signature register with synchronous seed reload.
module sbox_sig
    import sbox_loader_pkg::*;
#(
    parameter logic [31:0] SEED = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] data,
    output logic [31:0] sig
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_step(sig, data);
        end
    end

endmodule

// File: rtl/sbox_loader.sv
// Write-side controller for sbox_ram: streams 16 rows into CA 0..15, then hands CEN back to the core.
// Define SBOX_LOADER_VERIFY_EN to add a signature-checked read-back pass after the load.
module sbox_loader
    import sbox_loader_pkg::*;
#(
    parameter int unsigned  WORDS    = SBOX_WORDS,
    parameter int unsigned  AW       = SBOX_AW,
    parameter logic [31:0]  SIG_SEED = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [31:0]   DIN,
    input  logic          DIN_VALID,
    output logic          DIN_READY,
    input  logic          CORE_CEN,
    output logic          INIT,
    output logic          CEN,
    output logic          WEN,
    output logic [AW-1:0] CA,
    output logic [31:0]   SI,
    input  logic [31:0]   SO,
    output logic          BUSY,
    output logic          SBOX_OK,
    output logic          ERR
);

    localparam int unsigned CW = AW + 1;
    localparam logic [AW:0] NW = CW'(WORDS);

    state_t        state, state_nx;
    logic [AW:0]   cnt, cnt_nx;
    logic          rdy_q, rdy_nx;
    logic          init_q, init_nx;
    logic          cen_q, cen_nx;
    logic          wen_q, wen_nx;
    logic [AW-1:0] ca_q, ca_nx;
    logic [31:0]   si_q, si_nx;
    logic          busy_q, busy_nx;
    logic          ok_q, ok_nx;

    logic hs;
    logic start_go;
    logic load_end;

    assign hs       = DIN_VALID & rdy_q;
    assign start_go = START && ((state == IDLE) || (state == DONE));
    // cnt reaches WORDS on the last handshake edge, so this cycle carries the final write.
    assign load_end = (state == LOAD) && (cnt == NW);

`ifdef SBOX_LOADER_VERIFY_EN
    logic [AW:0] vcnt, vcnt_nx;
    logic        err_q, err_nx;
    logic [31:0] sig_wr, sig_rd;
    logic        rd_en;
    logic        verify_end;
    logic        sig_match;

    // SO for the read issued at vcnt=i is present at vcnt=i+1.
    assign rd_en      = (state == VERIFY) && (vcnt != '0) && (vcnt <= NW);
    assign verify_end = (state == VERIFY) && (vcnt == CW'(WORDS + 1));
    assign sig_match  = (sig_wr == sig_rd);

    sbox_sig #(.SEED(SIG_SEED)) u_sig_wr (
        .clk  (CLK),
        .rst  (RST),
        .clr  (start_go),
        .en   (hs),
        .data (DIN),
        .sig  (sig_wr)
    );

    sbox_sig #(.SEED(SIG_SEED)) u_sig_rd (
        .clk  (CLK),
        .rst  (RST),
        .clr  (start_go),
        .en   (rd_en),
        .data (SO),
        .sig  (sig_rd)
    );
`else
    logic unused_in;
    assign unused_in = ^{SO, SIG_SEED};
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (START) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (load_end) begin
`ifdef SBOX_LOADER_VERIFY_EN
                    state_nx = VERIFY;
`else
                    state_nx = DONE;
`endif
                end
            end
            VERIFY: begin
`ifdef SBOX_LOADER_VERIFY_EN
                if (verify_end) begin
                    state_nx = DONE;
                end
`else
                state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cnt_nx  = cnt;
        rdy_nx  = 1'b0;
        init_nx = init_q;
        cen_nx  = 1'b0;
        wen_nx  = 1'b0;
        ca_nx   = ca_q;
        si_nx   = si_q;
        busy_nx = busy_q;
        ok_nx   = ok_q;
`ifdef SBOX_LOADER_VERIFY_EN
        vcnt_nx = vcnt;
        err_nx  = err_q;
`endif
        case (state)
            IDLE, DONE: begin
                init_nx = 1'b0;
                if (START) begin
                    cnt_nx  = '0;
                    ok_nx   = 1'b0;
                    busy_nx = 1'b1;
                    init_nx = 1'b1;
                    rdy_nx  = 1'b1;
`ifdef SBOX_LOADER_VERIFY_EN
                    err_nx  = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (hs) begin
                    cen_nx = 1'b1;
                    wen_nx = 1'b1;
                    ca_nx  = cnt[AW-1:0];
                    si_nx  = DIN;
                    cnt_nx = cnt + 1'b1;
                end
                rdy_nx = (cnt_nx < NW);
                if (load_end) begin
                    rdy_nx = 1'b0;
`ifdef SBOX_LOADER_VERIFY_EN
                    vcnt_nx = '0;
                    cen_nx  = 1'b1;
                    ca_nx   = '0;
`else
                    init_nx = 1'b0;
                    busy_nx = 1'b0;
                    ok_nx   = 1'b1;
`endif
                end
            end
            VERIFY: begin
`ifdef SBOX_LOADER_VERIFY_EN
                vcnt_nx = vcnt + 1'b1;
                if (vcnt < CW'(WORDS - 1)) begin
                    cen_nx = 1'b1;
                    ca_nx  = vcnt[AW-1:0] + 1'b1;
                end
                if (verify_end) begin
                    init_nx = 1'b0;
                    busy_nx = 1'b0;
                    ok_nx   = sig_match;
                    err_nx  = !sig_match;
                end
`endif
            end
            default: begin
                init_nx = 1'b0;
                busy_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt    <= '0;
            rdy_q  <= 1'b0;
            init_q <= 1'b0;
            cen_q  <= 1'b0;
            wen_q  <= 1'b0;
            ca_q   <= '0;
            si_q   <= '0;
            busy_q <= 1'b0;
            ok_q   <= 1'b0;
`ifdef SBOX_LOADER_VERIFY_EN
            vcnt   <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            cnt    <= cnt_nx;
            rdy_q  <= rdy_nx;
            init_q <= init_nx;
            cen_q  <= cen_nx;
            wen_q  <= wen_nx;
            ca_q   <= ca_nx;
            si_q   <= si_nx;
            busy_q <= busy_nx;
            ok_q   <= ok_nx;
`ifdef SBOX_LOADER_VERIFY_EN
            vcnt   <= vcnt_nx;
            err_q  <= err_nx;
`endif
        end
    end

    // The core regains CEN in the same cycle INIT falls.
    assign CEN       = init_q ? cen_q : CORE_CEN;
    assign DIN_READY = rdy_q;
    assign INIT      = init_q;
    assign WEN       = wen_q;
    assign CA        = ca_q;
    assign SI        = si_q;
    assign BUSY      = busy_q;
    assign SBOX_OK   = ok_q;
`ifdef SBOX_LOADER_VERIFY_EN
    assign ERR       = err_q;
`else
    assign ERR       = 1'b0;
`endif

endmodule

// File: doc/sbox_loader.md
Name: sbox_loader

Overview:
- Write-side controller for sbox_ram: accepts 16 S-box words over a valid/ready stream and writes them at common addresses 0..15.
- Drives INIT/CEN/WEN/CA/SI of sbox_ram during the load, then hands the RAM back to the cipher core by dropping INIT.
- Muxes the core's chip-enable and tracks whether the RAM holds a complete table.

Parameters:
- WORDS, 16, number of S-box rows loaded per table; fixed to 2^AW.
- AW, 4, common-address width (CA).
- SIG_SEED, 32'h0000_0000, initial value of the load signature (verify feature).

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous reset, active-high
- START  in  1  one-cycle pulse; begins a load from IDLE/DONE
- DIN  in  32  S-box row word; nibble i goes to RAM i
- DIN_VALID  in  1  DIN qualifier
- DIN_READY  out  1  loader accepts DIN this cycle
- CORE_CEN  in  1  cipher core chip-enable, used when not loading
- INIT  out  1  to sbox_ram; 1 = CA addressing (load/verify)
- CEN  out  1  to sbox_ram chip-enable, active-high
- WEN  out  1  to sbox_ram; 1 = write, 0 = read
- CA  out  AW  to sbox_ram common address
- SI  out  32  to sbox_ram write data
- SO  in  32  from sbox_ram read data; valid one cycle after a read
- BUSY  out  1  load or verify in progress
- SBOX_OK  out  1  RAM holds a complete, accepted table
- ERR  out  1  verify mismatch (sticky until next START/RST)

Behaviour:
- Clocking: one clock CLK; RST is synchronous, active-high. All RAM-side outputs and status outputs are registered.
- Reset values: INIT=0, CEN=0, WEN=0, CA=0, SI=0, DIN_READY=0, BUSY=0, SBOX_OK=0, ERR=0; state IDLE; counter 0.
- States: IDLE, LOAD, VERIFY (feature only), DONE.
- IDLE/DONE:
  - INIT=0; CEN follows CORE_CEN combinationally through the mux; WEN=0.
  - START -> LOAD: counter=0, SBOX_OK=0, ERR=0, BUSY=1, INIT=1.
- LOAD:
  - DIN_READY=1 while counter<WORDS.
  - Each handshake (DIN_VALID&DIN_READY) at counter k produces, on the next cycle, a one-cycle write: CEN=1, WEN=1, CA=k, SI=DIN. The counter then increments.
  - No handshake -> CEN=0, WEN=0, INIT held 1.
  - Back-to-back handshakes give one write per cycle.
  - After the 16th handshake, DIN_READY drops the same cycle and the last write issues the next cycle.
  - The cycle after the last write -> DONE (or VERIFY with the feature).
- DONE entry: INIT=0, BUSY=0, SBOX_OK=1. CORE_CEN regains the RAM on the same cycle INIT falls.
- START while BUSY: ignored.
- DIN_VALID outside LOAD: ignored; DIN_READY=0.
- CORE_CEN while INIT=1: ignored; the loader owns CEN.
- CA wraps 15->0 only by re-entering LOAD; no write ever targets CA>15.
- RST mid-load: immediate return to reset values; the RAM contents are partial and SBOX_OK stays 0 until a full load completes.

Optional Feature:
- Macro SBOX_LOADER_VERIFY_EN.
- With the macro:
  - During LOAD, sig = {sig[30:0],sig[31]} ^ DIN on each handshake, seeded with SIG_SEED at START.
  - VERIFY issues 16 reads (CEN=1, WEN=0, CA=0..15, one per cycle, INIT=1) and captures SO one cycle after each read.
  - The same signature is computed over the readback and compared one cycle after the last SO capture.
  - Match -> DONE with SBOX_OK=1. Mismatch -> DONE with ERR=1, SBOX_OK=0.
  - VERIFY takes exactly 18 cycles.
- Without the macro: no VERIFY state and no signature registers; ERR is tied 0; SO is unused.

Decomposition:
- Shared package gets:
  - state enum {IDLE, LOAD, VERIFY, DONE};
  - constants SBOX_WORDS=16 and SBOX_AW=4;
  - the signature step as a function sig_step(sig, word).
- One natural sub-module, sbox_sig, holds the rotate-XOR signature register (clear, enable, data). It is instantiated twice under the macro (write side, read side).

Test Plan:
- Full load, VALID held high, DIN=32'h0000_0000+k·32'h1111_1111 -> 16 consecutive write cycles with CA=0..15 and SI matching; SBOX_OK=1 and INIT=0 exactly one cycle after the CA=15 write; sbox_ram readback via SA equals the loaded nibbles.
- Gappy source, VALID toggling 1,0,0,1 pattern -> writes only on cycles after handshakes; CEN=0 in gaps; INIT stays 1; 16 total writes.
- RST asserted after the 7th handshake -> next cycle all outputs at reset values, SBOX_OK=0. A fresh START with a full load then gives SBOX_OK=1.
- START pulsed mid-load, and DIN_VALID asserted in IDLE -> no restart, no extra writes, DIN_READY=0 in IDLE.
- Handover: CORE_CEN=1 throughout the load -> CEN is driven only by the loader while INIT=1, and equals CORE_CEN from the DONE entry cycle onward.
- (VERIFY_EN) load DIN=32'hA5A5_A5A5 for all rows -> ERR=0, SBOX_OK=1 after 18 verify cycles. Force one SO nibble wrong during readback -> ERR=1, SBOX_OK=0.
